uart_mmio_ctrl: RTL and testbench

Memory-mapped controller that sequences the UART transmit and receive paths for the CPU's load/store stage. It buffers outgoing bytes in a TX FIFO and drains them to the UART transmitter with a ready/valid handshake. It captures incoming bytes from the UART receiver into an RX FIFO. It also exposes a status register at the UART I/O addresses.

---
 rtl/uart_mmio_ctrl.sv | 132 +++++++++++++
 tb/tb_uart_mmio_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: TX FIFO drained over a ready/valid handshake,
// RX FIFO filled from the receiver, plus a STATUS/CTRL register in a 16-byte window.
module uart_mmio_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          TX_DEPTH  = 4,
    parameter int          RX_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [7:0]  wdata,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int TCW = TAW + 1;
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int RCW = RAW + 1;

    logic [7:0]     tx_mem [TX_DEPTH];
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [TAW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [RAW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [TCW-1:0] tx_cnt_q, tx_cnt_d;
    logic [RCW-1:0] rx_cnt_q, rx_cnt_d;
    logic           ovf_q, ovf_d, drop_q, drop_d;
    logic [31:0]    rdata_q, rdata_d;

    logic        hit, tx_full, rx_full, rx_empty;
    logic        rd_status, rd_rx, wr_ctrl, wr_tx;
    logic        tx_push, tx_pop, rx_push, rx_pop;
    logic [31:0] status_word;

    assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
    assign rd_status = rd_en && hit && (addr[3:0] == 4'h0);
    assign rd_rx     = rd_en && hit && (addr[3:0] == 4'h4);
    assign wr_ctrl   = wr_en && hit && (addr[3:0] == 4'h0);
    assign wr_tx     = wr_en && hit && (addr[3:0] == 4'h8);

    assign tx_full  = (tx_cnt_q == TCW'(TX_DEPTH));
    assign rx_full  = (rx_cnt_q == RCW'(RX_DEPTH));
    assign rx_empty = (rx_cnt_q == '0);

    assign tx_valid = (tx_cnt_q != '0);
    assign tx_data  = tx_mem[tx_rd_ptr_q];
    assign rdata    = rdata_q;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept a push.
    assign tx_pop  = tx_valid && tx_ready;
    assign tx_push = wr_tx && (!tx_full || tx_pop);
    assign rx_pop  = rd_rx && !rx_empty;
    assign rx_push = rx_valid && (!rx_full || rx_pop);

    assign status_word = {8'h00, 8'(rx_cnt_q), 8'(tx_cnt_q), 4'h0,
                          drop_q, ovf_q, !rx_empty, !tx_full};

    always_comb begin
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        tx_cnt_d    = tx_cnt_q;
        rx_cnt_d    = rx_cnt_q;
        ovf_d       = ovf_q;
        drop_d      = drop_q;
        rdata_d     = rdata_q;

        if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + TAW'(1);
        if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + TAW'(1);
        if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + RAW'(1);
        if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + RAW'(1);

        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + TCW'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - TCW'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + RCW'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - RCW'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase

        // Clear first so a same-cycle set overrides it.
        if (wr_ctrl && wdata[2]) ovf_d  = 1'b0;
        if (wr_ctrl && wdata[3]) drop_d = 1'b0;
        if (rx_valid && !rx_push) ovf_d  = 1'b1;
        if (wr_tx && !tx_push)    drop_d = 1'b1;

        if (rd_en) begin
            rdata_d = 32'h0;
            if (rd_status)   rdata_d = status_word;
            else if (rx_pop) rdata_d = {24'h0, rx_mem[rx_rd_ptr_q]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            ovf_q       <= 1'b0;
            drop_q      <= 1'b0;
            rdata_q     <= 32'h0;
        end else begin
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
            rdata_q     <= rdata_d;
        end
    end

    // Storage needs no reset: the counts alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr_q] <= wdata;
        if (rx_push) rx_mem[rx_wr_ptr_q] <= rx_data;
    end
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed plus randomized checks of uart_mmio_ctrl against a queue-based model
// of the register map and FIFO rules.
module tb_uart_mmio_ctrl;
    localparam int          TXD  = 4;
    localparam int          RXD  = 4;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] ST   = 32'h8000_0000;
    localparam logic [31:0] RXA  = 32'h8000_0004;
    localparam logic [31:0] TXA  = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] addr = '0;
    logic        rd_en = 1'b0, wr_en = 1'b0;
    logic [7:0]  wdata = '0;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_tx [$];
    logic [7:0]  m_rx [$];
    logic        m_ovf = 1'b0, m_drop = 1'b0;
    logic [31:0] exp_rdata = '0;

    uart_mmio_ctrl #(.BASE_ADDR(BASE), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
        .wdata(wdata), .rdata(rdata), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rd_en = 1'b0; wr_en = 1'b0; rx_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        m_tx.delete(); m_rx.delete();
        m_ovf = 1'b0; m_drop = 1'b0; exp_rdata = '0;
        tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock cycle: drive inputs, check handshake outputs, advance model, check rdata.
    task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [7:0] wd,
                        input logic tr, input logic rv, input logic [7:0] rxd);
        logic [31:0] status;
        logic        hit, tpop, clr_o, clr_d, set_o, set_d;
        rd_en = r; wr_en = w; addr = a; wdata = wd; tx_ready = tr; rx_valid = rv; rx_data = rxd;
        #1;
        chk("tx_valid", {31'h0, tx_valid}, {31'h0, m_tx.size() != 0});
        if (m_tx.size() != 0) chk("tx_data", {24'h0, tx_data}, {24'h0, m_tx[0]});

        status = {8'h00, 8'(m_rx.size()), 8'(m_tx.size()), 4'h0, m_drop, m_ovf,
                  m_rx.size() != 0, m_tx.size() != TXD};
        hit  = (a[31:4] == BASE[31:4]);
        tpop = (m_tx.size() != 0) && tr;
        clr_o = 1'b0; clr_d = 1'b0; set_o = 1'b0; set_d = 1'b0;
        if (r) begin
            if (hit && a[3:0] == 4'h0) exp_rdata = status;
            else if (hit && a[3:0] == 4'h4 && m_rx.size() != 0) exp_rdata = {24'h0, m_rx.pop_front()};
            else exp_rdata = 32'h0;
        end
        if (tpop) void'(m_tx.pop_front());
        if (w && hit && a[3:0] == 4'h8) begin
            if (m_tx.size() < TXD) m_tx.push_back(wd);
            else set_d = 1'b1;
        end
        if (w && hit && a[3:0] == 4'h0) begin
            clr_o = wd[2]; clr_d = wd[3];
        end
        if (rv) begin
            if (m_rx.size() < RXD) m_rx.push_back(rxd);
            else set_o = 1'b1;
        end
        if (clr_o) m_ovf = 1'b0;
        if (clr_d) m_drop = 1'b0;
        if (set_o) m_ovf = 1'b1;
        if (set_d) m_drop = 1'b1;

        @(posedge clk);
        #1;
        rd_en = 1'b0; wr_en = 1'b0; rx_valid = 1'b0;
        chk("rdata", rdata, exp_rdata);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rnd;
        int          sel;
        #1;
        do_reset();
        chk("reset_rdata", rdata, 32'h0);
        step(1, 0, ST, 0, 0, 0, 0);
        chk("status_reset", rdata, 32'h0000_0001);

        // TX drain
        step(0, 1, TXA, 8'h41, 0, 0, 0);
        step(0, 1, TXA, 8'h42, 0, 0, 0);
        step(1, 0, ST, 0, 0, 0, 0);
        chk("status_tx2", rdata, 32'h0000_0201);
        chk("tx_valid_tx2", {31'h0, tx_valid}, 32'h1);
        chk("tx_data_tx2", {24'h0, tx_data}, 32'h41);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("tx_data_second", {24'h0, tx_data}, 32'h42);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("tx_valid_drained", {31'h0, tx_valid}, 32'h0);

        // TX drop and clear
        for (int i = 0; i < 5; i++) step(0, 1, TXA, 8'hA0 + 8'(i), 0, 0, 0);
        step(1, 0, ST, 0, 0, 0, 0);
        chk("status_drop", rdata, 32'h0000_0408);
        step(0, 1, ST, 8'h08, 0, 0, 0);
        step(1, 0, ST, 0, 0, 0, 0);
        chk("status_drop_clr", rdata, 32'h0000_0400);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, 0);

        // RX overflow
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 8'h10 + 8'(i));
        step(1, 0, ST, 0, 0, 0, 0);
        chk("status_ovf", rdata, 32'h0004_0007);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, RXA, 0, 0, 0, 0);
            chk("rx_read", rdata, (i < 4) ? 32'h10 + 32'(i) : 32'h0);
        end
        step(0, 1, ST, 8'h04, 0, 0, 0);

        // RX full with simultaneous push and pop
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 8'h20 + 8'(i));
        step(1, 0, RXA, 0, 0, 1, 8'h55);
        chk("rx_full_pop", rdata, 32'h20);
        step(1, 0, ST, 0, 0, 0, 0);
        chk("status_full_same", rdata, 32'h0004_0003);
        for (int i = 0; i < 4; i++) step(1, 0, RXA, 0, 0, 0, 0);
        chk("rx_last_55", rdata, 32'h55);

        // Async reset mid-drain
        for (int i = 0; i < 3; i++) step(0, 1, TXA, 8'hC0 + 8'(i), 0, 0, 0);
        tx_ready = 1'b1;
        #2;
        do_reset();
        step(1, 0, ST, 0, 0, 0, 0);
        chk("status_after_rst", rdata, 32'h0000_0001);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            sel = int'($urandom_range(0, 9));
            rnd = $urandom();
            case (sel)
                0:       ra = {4'h1, rnd[27:0]};
                1:       ra = BASE | 32'(rnd[3:0]);
                2, 3:    ra = ST;
                4, 5, 6: ra = RXA;
                default: ra = TXA;
            endcase
            if ($urandom_range(0, 249) == 0) do_reset();
            step($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 5, ra, rnd[15:8],
                 $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4, rnd[23:16]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
